// File: rtl/playseq_unidade_controle.sv
// PlaySeq control unit: Moore FSM that sequences one game (preview, moves, compare, grow).
// Strobes are registered from the next state, so they line up with db_estado.
module playseq_unidade_controle #(
  parameter bit PREVIEW_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       fimE,
  input  logic       fimS,
  input  logic       igual,
  input  logic       enderecoIgualSequencia,
  input  logic       tem_jogada,
  input  logic       controle_timeout,
  input  logic       controle_timeout_led,
  input  logic       pare,
  input  logic       vai_escrever,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraS,
  output logic       contaS,
  output logic       carregaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraT_leds,
  output logic       contaT_leds,
  output logic       zeraJ,
  output logic       contaJ,
  output logic       controla_leds,
  output logic       fase_preview,
  output logic       ram_escreve,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic       sessao_fim,
  output logic [4:0] db_estado
);

  typedef enum logic [4:0] {
    INICIAL        = 5'h00, PREPARACAO     = 5'h01, INICIO_RODADA  = 5'h02,
    MOSTRA_LED     = 5'h03, APAGA_LED      = 5'h04, PROXIMO_LED    = 5'h05,
    FIM_PREVIEW    = 5'h06, ESPERA_JOGADA  = 5'h07, REGISTRA       = 5'h08,
    COMPARA        = 5'h09, PROXIMA_JOGADA = 5'h0A, ULTIMA_RODADA  = 5'h0B,
    PROXIMA_SEQ    = 5'h0C, CONTA_PARTIDA  = 5'h0D, FIM_ACERTOU    = 5'h0E,
    FIM_ERROU      = 5'h0F, FIM_TIMEOUT    = 5'h10
  } estado_t;

  typedef struct packed {
    logic zeraE, contaE, zeraS, contaS, carregaS, zeraR, registraR;
    logic zeraT, contaT, zeraT_leds, contaT_leds, zeraJ, contaJ;
    logic controla_leds, fase_preview, acertou, errou, timeout, pronto;
  } ctl_t;

  estado_t estado, prox;
  ctl_t    ctl;

  function automatic ctl_t decode(estado_t s);
    ctl_t c;
    c = '0;
    case (s)
      INICIAL:        c.zeraJ = 1'b1;
      PREPARACAO:     begin c.zeraE = 1'b1; c.carregaS = 1'b1; c.zeraR = 1'b1;
                            c.zeraT = 1'b1; c.zeraT_leds = 1'b1; end
      INICIO_RODADA:  begin c.zeraE = 1'b1; c.zeraT_leds = 1'b1; end
      MOSTRA_LED:     begin c.fase_preview = 1'b1; c.controla_leds = 1'b1; c.contaT_leds = 1'b1; end
      APAGA_LED:      begin c.fase_preview = 1'b1; c.contaT_leds = 1'b1; end
      PROXIMO_LED:    begin c.fase_preview = 1'b1; c.contaE = 1'b1; end
      FIM_PREVIEW:    begin c.zeraE = 1'b1; c.zeraT = 1'b1; end
      ESPERA_JOGADA:  c.contaT = 1'b1;
      REGISTRA:       c.registraR = 1'b1;
      PROXIMA_JOGADA: begin c.contaE = 1'b1; c.zeraT = 1'b1; end
      PROXIMA_SEQ:    begin c.contaS = 1'b1; c.zeraE = 1'b1; c.zeraT = 1'b1; end
      CONTA_PARTIDA:  c.contaJ = 1'b1;
      FIM_ACERTOU:    begin c.acertou = 1'b1; c.pronto = 1'b1; end
      FIM_ERROU:      begin c.errou = 1'b1; c.pronto = 1'b1; end
      FIM_TIMEOUT:    begin c.timeout = 1'b1; c.pronto = 1'b1; end
      default:        c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:        if (iniciar) prox = PREPARACAO;
      PREPARACAO:     prox = INICIO_RODADA;
      INICIO_RODADA:  prox = PREVIEW_EN ? MOSTRA_LED : FIM_PREVIEW;
      MOSTRA_LED:     if (controle_timeout_led) prox = APAGA_LED;
      APAGA_LED:      if (controle_timeout_led)
                        prox = enderecoIgualSequencia ? FIM_PREVIEW : PROXIMO_LED;
      PROXIMO_LED:    prox = MOSTRA_LED;
      FIM_PREVIEW:    prox = ESPERA_JOGADA;
      // a move wins over a timeout arriving in the same cycle
      ESPERA_JOGADA:  if (tem_jogada) prox = REGISTRA;
                      else if (controle_timeout) prox = FIM_TIMEOUT;
      REGISTRA:       prox = COMPARA;
      COMPARA:        if (!igual && !vai_escrever) prox = FIM_ERROU;
                      else if (enderecoIgualSequencia) prox = ULTIMA_RODADA;
                      else prox = PROXIMA_JOGADA;
      PROXIMA_JOGADA: prox = ESPERA_JOGADA;
      ULTIMA_RODADA:  prox = fimE ? CONTA_PARTIDA : PROXIMA_SEQ;
      PROXIMA_SEQ:    prox = INICIO_RODADA;
      CONTA_PARTIDA:  prox = FIM_ACERTOU;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                      if (iniciar) prox = PREPARACAO;
      default:        prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= INICIAL;
      ctl    <= decode(INICIAL);
    end else begin
      estado <= prox;
      ctl    <= decode(prox);
    end
  end

  assign {zeraE, contaE, zeraS, contaS, carregaS, zeraR, registraR} =
         {ctl.zeraE, ctl.contaE, ctl.zeraS, ctl.contaS, ctl.carregaS, ctl.zeraR, ctl.registraR};
  assign {zeraT, contaT, zeraT_leds, contaT_leds, zeraJ, contaJ} =
         {ctl.zeraT, ctl.contaT, ctl.zeraT_leds, ctl.contaT_leds, ctl.zeraJ, ctl.contaJ};
  assign {controla_leds, fase_preview, acertou, errou, timeout, pronto} =
         {ctl.controla_leds, ctl.fase_preview, ctl.acertou, ctl.errou, ctl.timeout, ctl.pronto};

  // the only input-dependent outputs: write enable and session end gated by state
  assign ram_escreve = (estado == REGISTRA) && vai_escrever;
  assign sessao_fim  = (estado == FIM_ACERTOU) && pare;
  assign db_estado   = estado;

  logic unused;
  assign unused = fimS;

endmodule
